// File: rtl/line_buffer_ctrl.sv
// line_buffer_ctrl
//   Sequences four external line buffers into a 3x3 sliding-window source.
//   Incoming pixels are written round-robin, one full line per buffer. Once
//   three lines are resident, three adjacent buffers are read in lockstep and
//   their 24-bit taps are muxed into a 72-bit window (oldest row in the MSBs).
//   A one-cycle interrupt marks each fully consumed line.
//
// Ports
//   i_clk               clock, rising edge
//   i_rst               asynchronous active-high reset
//   i_pixel_data        incoming 8-bit pixel
//   i_pixel_data_valid  pixel qualifier
//   i_lb_data           taps of buffers {lb3,lb2,lb1,lb0}, 24 bits each
//   o_lb_data           pixel broadcast to all buffers
//   o_lb_wr_valid       one-hot write enable per buffer
//   o_lb_rd             read-pointer advance per buffer
//   o_pixel_data        3x3 window
//   o_pixel_data_valid  window qualifier
//   o_intr              one-cycle pulse per consumed line
//   o_line_count        completed read lines (LB_CTRL_STATS_EN), else 0
//
// Build option
//   LB_CTRL_STATS_EN    when defined, o_line_count counts o_intr pulses
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for three resident lines, no read in progress
// RD    | reading one line from three adjacent buffers, window valid

module line_buffer_ctrl #(
    parameter int LINE_WIDTH = 512,
    parameter int CNT_W      = 12
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_pixel_data,
    input  logic        i_pixel_data_valid,
    input  logic [95:0] i_lb_data,
    output logic [7:0]  o_lb_data,
    output logic [3:0]  o_lb_wr_valid,
    output logic [3:0]  o_lb_rd,
    output logic [71:0] o_pixel_data,
    output logic        o_pixel_data_valid,
    output logic        o_intr,
    output logic [15:0] o_line_count
);

    localparam int PTR_W = $clog2(LINE_WIDTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(LINE_WIDTH - 1);
    localparam logic [CNT_W-1:0] RD_THRESH = CNT_W'(3 * LINE_WIDTH);

    typedef enum logic {
        IDLE = 1'b0,
        RD   = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              rd_active;
    logic              rd_done;
    logic [PTR_W-1:0]  wr_cnt;
    logic [PTR_W-1:0]  rd_cnt;
    logic [1:0]        wr_sel;
    logic [1:0]        rd_sel;
    logic [1:0]        rd_sel_p1;
    logic [1:0]        rd_sel_p2;
    logic [CNT_W-1:0]  total;
    logic              intr_q;
    logic [23:0]       tap [4];

    // ---------------- write side ----------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_cnt <= '0;
            wr_sel <= 2'd0;
        end else if (i_pixel_data_valid) begin
            if (wr_cnt == PTR_LAST) begin
                wr_cnt <= '0;
                wr_sel <= wr_sel + 2'd1;
            end else begin
                wr_cnt <= wr_cnt + 1'b1;
            end
        end
    end

    assign o_lb_data     = i_pixel_data;
    assign o_lb_wr_valid = i_pixel_data_valid ? (4'b0001 << wr_sel) : 4'b0000;

    // ---------------- occupancy ----------------
    // A simultaneous write and read cancel out.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            total <= '0;
        end else begin
            case ({i_pixel_data_valid, rd_active})
                2'b10:   total <= total + 1'b1;
                2'b01:   total <= total - 1'b1;
                default: total <= total;
            endcase
        end
    end

    // ---------------- read FSM ----------------
    assign rd_active = (state == RD);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rd_done   = 1'b0;
        case (state)
            IDLE: begin
                if (total >= RD_THRESH) begin
                    state_nxt = RD;
                end
            end
            RD: begin
                if (rd_cnt == PTR_LAST) begin
                    rd_done   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd_cnt <= '0;
            rd_sel <= 2'd0;
            intr_q <= 1'b0;
        end else begin
            intr_q <= rd_done;
            if (rd_done) begin
                rd_cnt <= '0;
                rd_sel <= rd_sel + 2'd1;
            end else if (rd_active) begin
                rd_cnt <= rd_cnt + 1'b1;
            end
        end
    end

    // ---------------- read outputs ----------------
    // 2-bit adds wrap naturally mod 4.
    assign rd_sel_p1 = rd_sel + 2'd1;
    assign rd_sel_p2 = rd_sel + 2'd2;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            tap[k] = i_lb_data[24*k +: 24];
        end
    end

    assign o_pixel_data_valid = rd_active;
    assign o_lb_rd            = rd_active ? ((4'b0001 << rd_sel) |
                                             (4'b0001 << rd_sel_p1) |
                                             (4'b0001 << rd_sel_p2)) : 4'b0000;
    assign o_pixel_data       = {tap[rd_sel], tap[rd_sel_p1], tap[rd_sel_p2]};
    assign o_intr             = intr_q;

    // ---------------- optional statistics ----------------
`ifdef LB_CTRL_STATS_EN
    logic [15:0] line_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            line_cnt <= 16'd0;
        end else if (intr_q) begin
            line_cnt <= line_cnt + 16'd1;
        end
    end

    assign o_line_count = line_cnt;
`else
    assign o_line_count = 16'd0;
`endif

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// tb_line_buffer_ctrl
//   Bench for line_buffer_ctrl. A pixel/line-level model tracks how many
//   pixels were written, how many lines were read and how far the current
//   line read has progressed; expected outputs are derived from those counts.
//   Directed phases add literal checks at the interesting points.

module tb_line_buffer_ctrl;

    localparam int LW = 512;

    logic        i_clk;
    logic        i_rst;
    logic [7:0]  i_pixel_data;
    logic        i_pixel_data_valid;
    logic [95:0] i_lb_data;
    logic [7:0]  o_lb_data;
    logic [3:0]  o_lb_wr_valid;
    logic [3:0]  o_lb_rd;
    logic [71:0] o_pixel_data;
    logic        o_pixel_data_valid;
    logic        o_intr;
    logic [15:0] o_line_count;

    int total;
    int bad;
    int intr_seen;
    int base;

    line_buffer_ctrl #(.LINE_WIDTH(LW), .CNT_W(12)) dut (
        .i_clk              (i_clk),
        .i_rst              (i_rst),
        .i_pixel_data       (i_pixel_data),
        .i_pixel_data_valid (i_pixel_data_valid),
        .i_lb_data          (i_lb_data),
        .o_lb_data          (o_lb_data),
        .o_lb_wr_valid      (o_lb_wr_valid),
        .o_lb_rd            (o_lb_rd),
        .o_pixel_data       (o_pixel_data),
        .o_pixel_data_valid (o_pixel_data_valid),
        .o_intr             (o_intr),
        .o_line_count       (o_line_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // ---------------- model ----------------
    int          m_pix;        // pixels written since reset
    int          m_occ;        // pixels resident
    int          m_rd_left;    // cycles left in current line read, 0 = none
    int          m_lines_read; // completed line reads
    logic        m_intr;
    logic [15:0] m_lc;

    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            m_pix        <= 0;
            m_occ        <= 0;
            m_rd_left    <= 0;
            m_lines_read <= 0;
            m_intr       <= 1'b0;
            m_lc         <= 16'd0;
        end else begin
            m_pix        <= m_pix + (i_pixel_data_valid ? 1 : 0);
            m_occ        <= m_occ + (i_pixel_data_valid ? 1 : 0) - ((m_rd_left > 0) ? 1 : 0);
            m_rd_left    <= (m_rd_left > 0) ? m_rd_left - 1 : ((m_occ >= 3*LW) ? LW : 0);
            m_lines_read <= m_lines_read + ((m_rd_left == 1) ? 1 : 0);
            m_intr       <= (m_rd_left == 1);
            m_lc         <= m_lc + (m_intr ? 16'd1 : 16'd0);
        end
    end

    function automatic logic [23:0] tap_of(int k);
        logic [95:0] d;
        d = i_lb_data;
        return d[24*(k%4) +: 24];
    endfunction

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_cycle();
        logic [3:0]  e_wr;
        logic [3:0]  e_rd;
        logic [71:0] e_win;
        logic        e_act;
        int          sel;
        e_act = (m_rd_left > 0);
        sel   = m_lines_read % 4;
        e_wr  = i_pixel_data_valid ? (4'b0001 << ((m_pix / LW) % 4)) : 4'b0000;
        e_rd  = 4'b0000;
        if (e_act) begin
            e_rd = (4'b0001 << sel) | (4'b0001 << ((sel+1)%4)) | (4'b0001 << ((sel+2)%4));
        end
        e_win = {tap_of(sel), tap_of(sel+1), tap_of(sel+2)};
        chk("wr_valid", 72'(o_lb_wr_valid), 72'(e_wr));
        chk("lb_data", 72'(o_lb_data), 72'(i_pixel_data));
        chk("pix_valid", 72'(o_pixel_data_valid), 72'(e_act));
        chk("lb_rd", 72'(o_lb_rd), 72'(e_rd));
        chk("intr", 72'(o_intr), 72'(m_intr));
`ifdef LB_CTRL_STATS_EN
        chk("line_count", 72'(o_line_count), 72'(m_lc));
`else
        chk("line_count", 72'(o_line_count), 72'd0);
`endif
        if (e_act) chk("window", o_pixel_data, e_win);
    endtask

    // One clock: compare on the falling edge, then step past the rising edge.
    task automatic tick();
        @(negedge i_clk);
        if (!i_rst) begin
            cmp_cycle();
            if (o_intr) intr_seen++;
        end
        @(posedge i_clk);
        #1;
        i_lb_data = {$urandom, $urandom, $urandom};
    endtask

    task automatic push(input int n);
        for (int i = 0; i < n; i++) begin
            i_pixel_data_valid = 1'b1;
            i_pixel_data       = 8'($urandom);
            tick();
        end
        i_pixel_data_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    localparam logic [95:0] TAPS = {24'h3D3D3D, 24'h2C2C2C, 24'h1B1B1B, 24'h0A0A0A};

    initial begin
        total = 0;
        bad = 0;
        intr_seen = 0;
        i_rst = 1'b1;
        i_pixel_data = 8'h00;
        i_pixel_data_valid = 1'b0;
        i_lb_data = '0;

        // reset state, before any clock edge
        #3;
        chk("rst_wr_valid", 72'(o_lb_wr_valid), 72'd0);
        chk("rst_lb_rd", 72'(o_lb_rd), 72'd0);
        chk("rst_pix_valid", 72'(o_pixel_data_valid), 72'd0);
        chk("rst_intr", 72'(o_intr), 72'd0);
        chk("rst_line_count", 72'(o_line_count), 72'd0);
        idle(3);
        i_rst = 1'b0;

        // fill three lines; literal write-select checks at line boundaries
        for (int i = 0; i < 1536; i++) begin
            i_pixel_data_valid = 1'b1;
            i_pixel_data       = 8'(i);
            #1;
            if (i == 0)    chk("wr_px0", 72'(o_lb_wr_valid), 72'h1);
            if (i == 511)  chk("wr_px511", 72'(o_lb_wr_valid), 72'h1);
            if (i == 512)  chk("wr_px512", 72'(o_lb_wr_valid), 72'h2);
            if (i == 1024) chk("wr_px1024", 72'(o_lb_wr_valid), 72'h4);
            if (i == 1535) chk("no_win_early", 72'(o_pixel_data_valid), 72'd0);
            tick();
        end
        i_pixel_data_valid = 1'b0;
        chk("no_win_at_N", 72'(o_pixel_data_valid), 72'd0);
        tick();
        i_lb_data = TAPS;
        #1;
        chk("first_valid", 72'(o_pixel_data_valid), 72'd1);
        chk("first_lb_rd", 72'(o_lb_rd), 72'h7);
        chk("first_window", o_pixel_data, 72'h0A0A0A_1B1B1B_2C2C2C);

        // drain: exactly one line read, then stall until more data
        base = intr_seen;
        idle(520);
        chk("one_intr", 72'(intr_seen - base), 72'd1);
        chk("idle_stall", 72'(o_pixel_data_valid), 72'd0);
        push(512);
        tick();
        i_lb_data = TAPS;
        #1;
        chk("second_lb_rd", 72'(o_lb_rd), 72'hE);
        chk("second_window", o_pixel_data, 72'h1B1B1B_2C2C2C_3D3D3D);
        idle(600);

        // continuous stream; pixel 2048 wraps back to buffer 0
        i_pixel_data_valid = 1'b1;
        #1;
        chk("wr_px2048", 72'(o_lb_wr_valid), 72'h1);
        base = intr_seen;
        push(2048);
        idle(1300);
        chk("stream_intrs", 72'(intr_seen - base), 72'd4);

        // asynchronous reset in the middle of a line read
        push(512);
        tick();
        idle(200);
        chk("mid_read_active", 72'(o_pixel_data_valid), 72'd1);
        #3;
        i_rst = 1'b1;
        #1;
        chk("arst_lb_rd", 72'(o_lb_rd), 72'd0);
        chk("arst_pix_valid", 72'(o_pixel_data_valid), 72'd0);
        chk("arst_intr", 72'(o_intr), 72'd0);
        chk("arst_line_count", 72'(o_line_count), 72'd0);
        chk("arst_wr_valid", 72'(o_lb_wr_valid), 72'd0);
        idle(3);
        i_rst = 1'b0;

        // restart from buffer 0, then three lines total for the statistics
        base = intr_seen;
        push(1536);
        tick();
        i_lb_data = TAPS;
        #1;
        chk("restart_lb_rd", 72'(o_lb_rd), 72'h7);
        chk("restart_window", o_pixel_data, 72'h0A0A0A_1B1B1B_2C2C2C);
        push(1024);
        idle(1300);
        chk("three_intrs", 72'(intr_seen - base), 72'd3);
`ifdef LB_CTRL_STATS_EN
        chk("stats_count", 72'(o_line_count), 72'd3);
`else
        chk("stats_count", 72'(o_line_count), 72'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
